lcd_page_scheduler: RTL and testbench

- Drives `lcd_16x2`, the 16x2 I2C character LCD, from up to NPAGES display pages: temperature, humidity, setpoints, alarm text and so on.
- Owns the `lcd_16x2` `ena`/`row1`/`row2` inputs and refreshes the current page periodically.
- Rotates round-robin through valid pages after a dwell count.
- Pre-empts to page 0 (the alarm page) when `alarm` is asserted.
- Row data is held stable for the whole refresh interval so an in-flight I2C update is never corrupted.

---
 rtl/lcd_pkg.sv | 15 +
 rtl/lcd_page_pick.sv | 30 +++
 rtl/lcd_page_scheduler.sv | 105 ++++++++++
 tb/tb_lcd_page_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD row geometry and scheduler state encoding
package lcd_pkg;

    localparam int LCD_ROW_W = 128;
    localparam int LCD_CHARS = 16;
    localparam logic [LCD_ROW_W-1:0] LCD_BLANK_ROW = {LCD_CHARS{8'h20}};

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        STROBE,
        WAIT
    } lcd_state_t;

endpackage

// File: rtl/lcd_page_pick.sv
// rtl/lcd_page_pick.sv - combinational round-robin search for the next valid page
module lcd_page_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] start,
    output logic [$clog2(N)-1:0] index,
    output logic                 found
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Scan start+N down to start+1 so the nearest valid page after start wins;
    // start itself is the last candidate, covering the single-valid-page case.
    always_comb begin
        index = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(start) + k) % N);
            if (valid[idx]) begin
                index = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_page_scheduler.sv
// rtl/lcd_page_scheduler.sv - periodic page refresh and rotation for the 16x2 LCD
module lcd_page_scheduler
    import lcd_pkg::*;
#(
    parameter int NPAGES          = 4,
    parameter int REFRESH_CYC     = 200000,
    parameter int DWELL_REFRESHES = 15
) (
    input  logic                          clk_1MHz,
    input  logic                          rst,
    input  logic [NPAGES-1:0]             page_valid,
    input  logic [NPAGES*LCD_ROW_W-1:0]   page_row1,
    input  logic [NPAGES*LCD_ROW_W-1:0]   page_row2,
    input  logic                          alarm,
    input  logic                          hold,
    output logic                          lcd_ena,
    output logic [LCD_ROW_W-1:0]          lcd_row1,
    output logic [LCD_ROW_W-1:0]          lcd_row2,
    output logic [$clog2(NPAGES)-1:0]     cur_page,
    output logic                          busy
);

    localparam int PW = $clog2(NPAGES);
    localparam int WW = $clog2(REFRESH_CYC + 1);

    lcd_state_t    state;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    dwell_cnt;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic [PW-1:0] next_page;

    lcd_page_pick #(.N(NPAGES)) u_pick (
        .valid (page_valid),
        .start (cur_page),
        .index (pick_idx),
        .found (pick_found)
    );

    // Alarm wins over everything; an invalidated page forces a move; otherwise rotate on dwell.
    always_comb begin
        next_page = cur_page;
        if (alarm && page_valid[0]) begin
            next_page = '0;
        end else if (!page_valid[cur_page]) begin
            next_page = pick_idx;
        end else if (!hold && dwell_cnt >= 8'(DWELL_REFRESHES)) begin
            next_page = pick_idx;
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state     <= IDLE;
            lcd_ena   <= 1'b0;
            lcd_row1  <= LCD_BLANK_ROW;
            lcd_row2  <= LCD_BLANK_ROW;
            cur_page  <= '0;
            dwell_cnt <= 8'd0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|page_valid) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (!pick_found) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cur_page <= next_page;
                        lcd_row1 <= page_row1[int'(next_page)*LCD_ROW_W +: LCD_ROW_W];
                        lcd_row2 <= page_row2[int'(next_page)*LCD_ROW_W +: LCD_ROW_W];
                        if (next_page != cur_page) begin
                            dwell_cnt <= 8'd0;
                        end
                        lcd_ena <= 1'b1;
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    lcd_ena  <= 1'b0;
                    wait_cnt <= '0;
                    if (dwell_cnt != 8'hFF) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WW'(REFRESH_CYC - 1)) begin
                        state <= LATCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// tb/tb_lcd_page_scheduler.sv - directed self-checking bench for lcd_page_scheduler
module tb_lcd_page_scheduler;

    localparam int NP  = 4;
    localparam int RC  = 8;
    localparam int DW  = 3;
    localparam int PER = RC + 2;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic             clk_1MHz = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    page_valid = '0;
    logic [NP*128-1:0] page_row1 = '0;
    logic [NP*128-1:0] page_row2 = '0;
    logic             alarm = 1'b0;
    logic             hold = 1'b0;
    logic             lcd_ena;
    logic [127:0]     lcd_row1;
    logic [127:0]     lcd_row2;
    logic [1:0]       cur_page;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    lcd_page_scheduler #(
        .NPAGES(NP),
        .REFRESH_CYC(RC),
        .DWELL_REFRESHES(DW)
    ) dut (
        .clk_1MHz   (clk_1MHz),
        .rst        (rst),
        .page_valid (page_valid),
        .page_row1  (page_row1),
        .page_row2  (page_row2),
        .alarm      (alarm),
        .hold       (hold),
        .lcd_ena    (lcd_ena),
        .lcd_row1   (lcd_row1),
        .lcd_row2   (lcd_row2),
        .cur_page   (cur_page),
        .busy       (busy)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    function automatic logic [127:0] row1_of(input int i);
        logic [7:0] c;
        c = 8'h30 + 8'(i);
        return {16{c}};
    endfunction

    function automatic logic [127:0] row2_of(input int i);
        logic [7:0] c;
        c = 8'h41 + 8'(i);
        return {16{c}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns the number of negedges until lcd_ena is seen high, or -1 on timeout.
    task automatic wait_strobe(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_1MHz);
            if (lcd_ena) begin
                n = i;
                return;
            end
        end
        check_eq("strobe_timeout", 128'(0), 128'(1));
    endtask

    task automatic do_reset(input logic [NP-1:0] v);
        rst = 1'b1;
        page_valid = '0;
        alarm = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge clk_1MHz);
        rst = 1'b0;
        page_valid = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ena_hi;
        int busy_hi;
        int exp_seq [10] = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 0};

        for (int i = 0; i < NP; i++) begin
            page_row1[128*i +: 128] = row1_of(i);
            page_row2[128*i +: 128] = row2_of(i);
        end

        // 1: idle with nothing valid
        do_reset('0);
        ena_hi = 0;
        busy_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_1MHz);
            if (lcd_ena) ena_hi++;
            if (busy) busy_hi++;
        end
        check_eq("s1_ena_count", 128'(ena_hi), 128'(0));
        check_eq("s1_busy_count", 128'(busy_hi), 128'(0));
        check_eq("s1_row1", lcd_row1, BLANK);
        check_eq("s1_row2", lcd_row2, BLANK);
        check_eq("s1_cur_page", 128'(cur_page), 128'(0));

        // 2: single valid page; ena appears two negedges after the drive (IDLE sample, LATCH, STROBE)
        do_reset(4'b0001);
        wait_strobe(20, n);
        check_eq("s2_latency", 128'(n), 128'(2));
        check_eq("s2_row1", lcd_row1, row1_of(0));
        check_eq("s2_row2", lcd_row2, row2_of(0));
        check_eq("s2_busy", 128'(busy), 128'(1));
        for (int k = 0; k < 4; k++) begin
            wait_strobe(20, n);
            check_eq("s2_period", 128'(n), 128'(PER));
            check_eq("s2_cur_page", 128'(cur_page), 128'(0));
        end

        // 3: round robin over 1011, page 2 skipped
        do_reset(4'b1011);
        for (int k = 0; k < 10; k++) begin
            wait_strobe(20, n);
            check_eq($sformatf("s3_page%0d", k), 128'(cur_page), 128'(exp_seq[k]));
            check_eq($sformatf("s3_row%0d", k), lcd_row1, row1_of(exp_seq[k]));
        end

        // 4: alarm pre-empts page 3 mid-WAIT, hold has no effect
        do_reset(4'b1011);
        for (int k = 0; k < 7; k++) wait_strobe(20, n);
        check_eq("s4_on_page3", 128'(cur_page), 128'(3));
        repeat (4) @(negedge clk_1MHz);
        alarm = 1'b1;
        hold = 1'b1;
        repeat (5) @(negedge clk_1MHz);
        check_eq("s4_row_held", lcd_row1, row1_of(3));
        check_eq("s4_page_held", 128'(cur_page), 128'(3));
        wait_strobe(20, n);
        check_eq("s4_alarm_latency", 128'(n), 128'(1));
        check_eq("s4_alarm_page", 128'(cur_page), 128'(0));
        check_eq("s4_alarm_row", lcd_row1, row1_of(0));
        for (int k = 0; k < 4; k++) begin
            wait_strobe(20, n);
            check_eq("s4_alarm_stay", 128'(cur_page), 128'(0));
        end
        alarm = 1'b0;
        hold = 1'b0;
        wait_strobe(20, n);
        check_eq("s4_release_rotate", 128'(cur_page), 128'(1));

        // 5: hold on page 1, then release; then alarm without valid page 0 and wrap past page 0
        do_reset(4'b1011);
        for (int k = 0; k < 4; k++) wait_strobe(20, n);
        check_eq("s5_on_page1", 128'(cur_page), 128'(1));
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_strobe(20, n);
            check_eq("s5_hold_page", 128'(cur_page), 128'(1));
        end
        hold = 1'b0;
        wait_strobe(20, n);
        check_eq("s5_release_page", 128'(cur_page), 128'(3));
        page_valid = 4'b1010;
        alarm = 1'b1;
        wait_strobe(20, n);
        check_eq("s5_noalarm_a", 128'(cur_page), 128'(3));
        wait_strobe(20, n);
        check_eq("s5_noalarm_b", 128'(cur_page), 128'(3));
        wait_strobe(20, n);
        check_eq("s5_wrap_skip0", 128'(cur_page), 128'(1));
        check_eq("s5_wrap_row2", lcd_row2, row2_of(1));
        alarm = 1'b0;

        // 6: reset during WAIT, then restart
        do_reset(4'b0001);
        wait_strobe(20, n);
        repeat (3) @(negedge clk_1MHz);
        rst = 1'b1;
        @(negedge clk_1MHz);
        check_eq("s6_ena", 128'(lcd_ena), 128'(0));
        check_eq("s6_row1", lcd_row1, BLANK);
        check_eq("s6_row2", lcd_row2, BLANK);
        check_eq("s6_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        wait_strobe(20, n);
        check_eq("s6_restart_latency", 128'(n), 128'(2));
        wait_strobe(20, n);
        check_eq("s6_restart_period", 128'(n), 128'(PER));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
